// File: rtl/lab3_serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-subtractor step per clock with a registered borrow.
// Optional signed-overflow output `ovf` is built only when SERIAL_SUB_OVF_EN is defined.
module lab3_serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_diff;
  logic             r_br;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;
  logic             w_load;
  logic             w_shift;
  logic             w_last;
  logic             w_d;
  logic             w_bo;

  // Half-subtractor pair chained through the borrow flip-flop.
  assign w_d     = r_sa[0] ^ r_sb[0] ^ r_br;
  assign w_bo    = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_br);
  assign w_load  = (r_state == S_IDLE) && start;
  assign w_shift = (r_state == S_SHIFT);
  assign w_last  = w_shift && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_SHIFT;
      S_SHIFT: if (r_cnt == LAST) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_SHIFT: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa     <= '0;
      r_sb     <= '0;
      r_sr     <= '0;
      r_br     <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
    end else if (w_load) begin
      r_sa  <= a;
      r_sb  <= b;
      r_sr  <= '0;
      r_br  <= 1'b0;
      r_cnt <= '0;
    end else if (w_shift) begin
      r_sa <= {1'b0, r_sa[WIDTH-1:1]};
      r_sb <= {1'b0, r_sb[WIDTH-1:1]};
      r_sr <= {w_d, r_sr[WIDTH-1:1]};
      r_br <= w_bo;
      // Hold the counter on the final step so it never wraps.
      if (w_last) begin
        r_diff   <= {w_d, r_sr[WIDTH-1:1]};
        r_borrow <= w_bo;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign diff   = r_diff;
  assign borrow = r_borrow;

`ifdef SERIAL_SUB_OVF_EN
  logic r_sign_a;
  logic r_sign_b;
  logic r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_load) begin
      r_sign_a <= a[WIDTH-1];
      r_sign_b <= b[WIDTH-1];
    end else if (w_last) begin
      r_ovf <= (r_sign_a != r_sign_b) && (w_d != r_sign_a);
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_lab3_serial_subtractor.sv
// Directed bench for lab3_serial_subtractor (WIDTH=8), expected values hand-computed.
`timescale 1ns/1ps
module tb_lab3_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ovf;

  int checks = 0;
  int errors = 0;

  lab3_serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

`ifndef SERIAL_SUB_OVF_EN
  assign ovf = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one op and follow it cycle-accurately through DONE and back to IDLE.
  task automatic run_op(input string tag, input logic [7:0] va, input logic [7:0] vb,
                        input logic [7:0] ed, input logic eb, input logic eo);
    a = va;
    b = vb;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, ".busy_after_start"}, 32'(busy), 32'd1);
    repeat (WIDTH - 1) tick();
    chk({tag, ".no_early_done"}, 32'(done), 32'd0);
    tick();
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".busy_in_done"}, 32'(busy), 32'd0);
    chk({tag, ".diff"}, 32'(diff), 32'(ed));
    chk({tag, ".borrow"}, 32'(borrow), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
    chk({tag, ".ovf"}, 32'(ovf), 32'(eo));
`else
    if (eo) ; // overflow only observable with the optional port
`endif
    tick();
    chk({tag, ".done_one_cycle"}, 32'(done), 32'd0);
    chk({tag, ".diff_held"}, 32'(diff), 32'(ed));
    chk({tag, ".borrow_held"}, 32'(borrow), 32'(eb));
  endtask

  initial begin
    int pulses;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    #23;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.diff", 32'(diff), 32'h00);
    chk("rst.borrow", 32'(borrow), 32'd0);
    chk("rst.ovf", 32'(ovf), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rel.busy", 32'(busy), 32'd0);
    chk("rel.diff", 32'(diff), 32'h00);

    run_op("5m3", 8'd5, 8'd3, 8'h02, 1'b0, 1'b0);
    run_op("3m5", 8'd3, 8'd5, 8'hFE, 1'b1, 1'b0);
    run_op("0m0", 8'd0, 8'd0, 8'h00, 1'b0, 1'b0);
    run_op("80m01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    run_op("7Fm_FF", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

    // Start pulsed mid-SHIFT must be ignored: one done, result of the first op.
    a = 8'd9;
    b = 8'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    pulses = 0;
    repeat (3) tick();
    a = 8'd1;
    b = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (done) begin
        pulses++;
        chk("busy_start.diff", 32'(diff), 32'h05);
        chk("busy_start.borrow", 32'(borrow), 32'd0);
      end
      tick();
    end
    chk("busy_start.pulses", 32'(pulses), 32'd1);
    chk("busy_start.idle", 32'(busy), 32'd0);

    // Asynchronous abort mid-SHIFT clears outputs at once.
    a = 8'h7F;
    b = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.done", 32'(done), 32'd0);
    chk("abort.diff", 32'(diff), 32'h00);
    chk("abort.borrow", 32'(borrow), 32'd0);
    chk("abort.ovf", 32'(ovf), 32'd0);
    tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) pulses++;
      tick();
    end
    chk("abort.no_delivery", 32'(pulses), 32'd0);
    run_op("10m01", 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lab3_serial_subtractor.md
# lab3_serial_subtractor

- Bit-serial N-bit subtractor computing `a - b` one bit per clock, LSB first.
- Per-bit core is the half-subtractor pair (difference and borrow), extended with a registered borrow-in to form a full-subtractor step.
- Sits downstream of the lab2 half-subtractor cell: it consumes that cell's D/B equations and chains them through a borrow flip-flop.
- A start/busy/done handshake lets a bench or controller launch one subtraction at a time and read a held result.

## Interface

Parameters:

- `WIDTH`, default 8 — operand and result width in bits; must be ≥ 2.

Ports (all single-bit unless noted):

- `clk` — input, 1 — system clock; all state updates on the rising edge.
- `rst_n` — input, 1 — reset, asynchronous and active-low.
- `start` — input, 1 — launch request; sampled only in IDLE.
- `a` — input, WIDTH — minuend; captured on an accepted start.
- `b` — input, WIDTH — subtrahend; captured on an accepted start.
- `busy` — output, 1 — high while in SHIFT.
- `done` — output, 1 — one-cycle pulse; high while in DONE.
- `diff` — output, WIDTH — result `a - b` mod 2^WIDTH; held until the next completion.
- `borrow` — output, 1 — final borrow-out; 1 means `a < b` unsigned; held with `diff`.
- `ovf` — output, 1 — signed overflow flag; present only with `SERIAL_SUB_OVF_EN`.

## Operation

State machine: IDLE, SHIFT, DONE.

- **IDLE**
  - `start`=1 loads `a` into shift register SA and `b` into SB, clears the borrow flip-flop BR and bit counter CNT, clears result shift register SR, then moves to SHIFT.
  - `start`=0 stays in IDLE.
- **SHIFT**, each cycle:
  - `d = SA[0] ^ SB[0] ^ BR`
  - `bo = (~SA[0] & SB[0]) | (~(SA[0] ^ SB[0]) & BR)`
  - SR shifts right with `d` entering the MSB; SA and SB shift right; BR ← `bo`; CNT increments.
  - On the cycle with CNT = WIDTH-1, SR's final value is copied to `diff` and `bo` to `borrow`, and the FSM moves to DONE.
- **DONE**: `done`=1 for exactly one cycle, then unconditional move to IDLE.
- `start` is ignored in SHIFT and DONE; there is no queuing.
- CNT is ⌈log2(WIDTH)⌉ bits wide and never wraps within an operation.
- `diff`/`borrow` change only at completion; they are stable from the DONE cycle until the next completion.

## Timing

- Reset values: state=IDLE; `busy`=0, `done`=0, `diff`=0, `borrow`=0, `ovf`=0; SA, SB, SR, BR, CNT all 0.
- `rst_n` low mid-operation aborts immediately and asynchronously to the reset values; the result of the aborted operation is never delivered.
- `start` sampled high at edge E0:
  - `busy`=1 after E0.
  - Bits are processed at edges E1..E_WIDTH.
  - `diff`/`borrow` update and `done`=1 after edge E_WIDTH.
  - IDLE after edge E_WIDTH+1.
- Latency from start edge to `done` is WIDTH cycles; back-to-back throughput is one operation per WIDTH+2 cycles.
- `start` held high continuously relaunches on every IDLE cycle.

## Configuration

- Macro: `SERIAL_SUB_OVF_EN`.
- **Defined:**
  - Port `ovf` exists.
  - Sign bits `a[WIDTH-1]` and `b[WIDTH-1]` are captured at load.
  - At completion, `ovf = (sa != sb) & (diff_new[WIDTH-1] != sa)`, where sa and sb are the captured sign bits.
  - `ovf` updates and holds alongside `diff`; its reset value is 0.
- **Undefined:** port `ovf` and the sign capture registers are absent; all other behaviour is identical.

## Test plan

All scenarios use WIDTH=8.

- **Reset state:** assert reset, then release → `busy`=0, `done`=0, `diff`=0x00, `borrow`=0.
- **Basic positive result:** start with a=5, b=3 → after 8 cycles `done` pulses one cycle with `diff`=0x02, `borrow`=0; outputs hold afterwards.
- **Negative result (unsigned borrow):** a=3, b=5 → `diff`=0xFE, `borrow`=1; a=0, b=0 → `diff`=0x00, `borrow`=0.
- **Signed overflow:** a=0x80, b=0x01 → `diff`=0x7F, `borrow`=0, `ovf`=1 when the macro is defined. a=0x7F, b=0xFF → `diff`=0x80, `borrow`=1, `ovf`=1.
- **Start while busy:** launch a=9, b=4, then pulse start with a=1, b=1 mid-SHIFT → a single `done` with `diff`=0x05; no second operation follows.
- **Reset mid-operation:** drop `rst_n` during SHIFT → all outputs 0 immediately; after release, launching a=0x10, b=0x01 gives `diff`=0x0F.
